// File: rtl/expr_pipe_pkg.sv
// expr_pipe_pkg: operator codes and shift-amount sizing shared by the expression pipeline
package expr_pipe_pkg;
  localparam int OP_W = 4;
  typedef enum logic [OP_W-1:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_LT, OP_EQ, OP_SHL, OP_ASHR, OP_XORR, OP_MUX
  } op_e;
  function automatic int shamt_w(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/expr_lane.sv
// expr_lane: one combinational channel ALU applying Verilog width/sign rules
module expr_lane import expr_pipe_pkg::*; #(
  parameter int W = 6
) (
  input  logic [OP_W-1:0] op,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic            a_signed,
  input  logic            b_signed,
  output logic [W-1:0]    y,
  output logic            div0
);
  localparam int SW = shamt_w(W);
  logic s, bz, lt;
  logic signed [W-1:0] sa, sb, sq, sr, sashr;
  logic [W-1:0] q, r;
  function automatic logic [W-1:0] zx(input logic x);
    return {{(W-1){1'b0}}, x};
  endfunction
  assign s = a_signed & b_signed;
  assign bz = b == '0;
  assign sa = a;
  assign sb = b;
  // signed results live in their own nets so mixed-sign ternaries below cannot demote them
  assign sq = sa / sb;
  assign sr = sa % sb;
  assign sashr = sa >>> b;
  assign q = bz ? '0 : s ? sq : a / b;
  assign r = bz ? '0 : s ? sr : a % b;
  assign lt = s ? sa < sb : a < b;
  assign div0 = bz && (op == OP_DIV || op == OP_MOD);
  assign y = op == OP_ADD  ? a + b
           : op == OP_SUB  ? a - b
           : op == OP_MUL  ? a * b
           : op == OP_DIV  ? q
           : op == OP_MOD  ? r
           : op == OP_LT   ? zx(lt)
           : op == OP_EQ   ? zx(a === b)
           : op == OP_SHL  ? a << b[SW-1:0]
           : op == OP_ASHR ? (a_signed ? sashr : a >> b)
           : op == OP_XORR ? zx(^{a, b})
           : op == OP_MUX  ? (a != '0 ? b : ~b)
           : '0;
endmodule

// File: rtl/expr_pipe_eval.sv
// expr_pipe_eval: NCH-channel expression evaluator behind an elastic STAGES-deep valid/ready pipeline
// Optional EXPR_PIPE_EVAL_PARITY_EN adds y_par, the even parity of each channel result.
module expr_pipe_eval import expr_pipe_pkg::*; #(
  parameter int W      = 6,
  parameter int NCH    = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [NCH*W-1:0] a_flat,
  input  logic [NCH*W-1:0] b_flat,
  input  logic [NCH-1:0]   a_signed,
  input  logic [NCH-1:0]   b_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NCH*W-1:0] y,
  output logic [NCH-1:0]   div0
`ifdef EXPR_PIPE_EVAL_PARITY_EN
  ,
  output logic [NCH-1:0]   y_par
`endif
);
  logic [NCH*W-1:0] ly;
  logic [NCH-1:0] ld, lp;
  logic [STAGES-1:0] load;
  logic v [STAGES];
  logic [NCH*W-1:0] yd [STAGES];
  logic [NCH-1:0] dd [STAGES];
  logic [NCH-1:0] pd [STAGES];
  for (genvar i = 0; i < NCH; i++) begin : g_lane
    expr_lane #(.W(W)) u_lane (
      .op(op), .a(a_flat[i*W +: W]), .b(b_flat[i*W +: W]),
      .a_signed(a_signed[i]), .b_signed(b_signed[i]),
      .y(ly[i*W +: W]), .div0(ld[i])
    );
    assign lp[i] = ^ly[i*W +: W];
  end
  // a slot may load when empty or when everything downstream of it moves this cycle
  always_comb begin
    logic l;
    l = out_ready;
    load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      l = !v[k] || l;
      load[k] = l;
    end
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic sv;
    logic [NCH*W-1:0] sy;
    logic [NCH-1:0] sd, sp;
    if (k == 0) begin : g_src
      assign sv = in_valid;
      assign sy = ly;
      assign sd = ld;
      assign sp = lp;
    end else begin : g_src
      assign sv = v[k-1];
      assign sy = yd[k-1];
      assign sd = dd[k-1];
      assign sp = pd[k-1];
    end
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v[k] <= 1'b0;
        yd[k] <= '0;
        dd[k] <= '0;
        pd[k] <= '0;
      end else if (load[k]) begin
        v[k] <= sv;
        if (sv) begin
          yd[k] <= sy;
          dd[k] <= sd;
          pd[k] <= sp;
        end
      end
    end
  end
  assign in_ready = load[0];
  assign out_valid = v[STAGES-1];
  assign y = yd[STAGES-1];
  assign div0 = dd[STAGES-1];
`ifdef EXPR_PIPE_EVAL_PARITY_EN
  assign y_par = pd[STAGES-1];
`else
  logic unused_par;
  assign unused_par = ^pd[STAGES-1];
`endif
endmodule

// File: tb/tb_expr_pipe_eval.sv
// tb_expr_pipe_eval: directed self-checking bench for expr_pipe_eval (W=6, NCH=6, STAGES=2)
module tb_expr_pipe_eval;
  import expr_pipe_pkg::*;
  localparam int W = 6;
  localparam int NCH = 6;
  localparam int STAGES = 2;
  logic clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [OP_W-1:0] op;
  logic [NCH*W-1:0] a_flat, b_flat, y;
  logic [NCH-1:0] a_signed, b_signed, div0;
`ifdef EXPR_PIPE_EVAL_PARITY_EN
  logic [NCH-1:0] y_par;
`endif
  int total = 0;
  int bad = 0;
  expr_pipe_eval #(.W(W), .NCH(NCH), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a_flat(a_flat), .b_flat(b_flat), .a_signed(a_signed), .b_signed(b_signed),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .div0(div0)
`ifdef EXPR_PIPE_EVAL_PARITY_EN
    , .y_par(y_par)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // offer one transaction on an empty pipe with all channels identical, wait (bounded) for its result
  task automatic xact(input logic [OP_W-1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic as, input logic bs, output logic [NCH*W-1:0] ry,
                      output logic [NCH-1:0] rd, output int lat);
    op = o;
    a_flat = {NCH{a}};
    b_flat = {NCH{b}};
    a_signed = {NCH{as}};
    b_signed = {NCH{bs}};
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick;
      lat++;
    end
    ry = y;
    rd = div0;
    tick;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    total++; if (y !== '0) begin bad++; $display("FAIL reset y: got %h want 0", y); end
    total++; if (div0 !== '0) begin bad++; $display("FAIL reset div0: got %b want 0", div0); end
    rst_n = 1'b1;
    tick;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
  endtask
  task automatic test_arith;
    logic [NCH*W-1:0] ry;
    logic [NCH-1:0] rd;
    int lat;
    xact(OP_ADD, 6'h3D, 6'h05, 1'b1, 1'b1, ry, rd, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL add latency: got %0d want 2", lat); end
    total++; if (ry !== {NCH{6'h02}}) begin bad++; $display("FAIL add y: got %h want %h", ry, {NCH{6'h02}}); end
    total++; if (rd !== '0) begin bad++; $display("FAIL add div0: got %b want 0", rd); end
    xact(OP_SUB, 6'h05, 6'h07, 1'b0, 1'b0, ry, rd, lat);
    total++; if (ry !== {NCH{6'h3E}}) begin bad++; $display("FAIL sub y: got %h want %h", ry, {NCH{6'h3E}}); end
    xact(OP_MUL, 6'h07, 6'h0A, 1'b0, 1'b0, ry, rd, lat);
    total++; if (ry !== {NCH{6'h06}}) begin bad++; $display("FAIL mul y: got %h want %h", ry, {NCH{6'h06}}); end
  endtask
  task automatic test_compare;
    logic [NCH*W-1:0] ry;
    logic [NCH-1:0] rd;
    int lat;
    xact(OP_LT, 6'h3F, 6'h01, 1'b1, 1'b0, ry, rd, lat);
    total++; if (ry !== {NCH{6'h00}}) begin bad++; $display("FAIL lt mixed y: got %h want 0", ry); end
    xact(OP_LT, 6'h3F, 6'h01, 1'b1, 1'b1, ry, rd, lat);
    total++; if (ry !== {NCH{6'h01}}) begin bad++; $display("FAIL lt signed y: got %h want %h", ry, {NCH{6'h01}}); end
    xact(OP_EQ, 6'h15, 6'h15, 1'b0, 1'b1, ry, rd, lat);
    total++; if (ry !== {NCH{6'h01}}) begin bad++; $display("FAIL eq y: got %h want %h", ry, {NCH{6'h01}}); end
  endtask
  task automatic test_shift;
    logic [NCH*W-1:0] ry;
    logic [NCH-1:0] rd;
    int lat;
    xact(OP_ASHR, 6'h30, 6'h02, 1'b1, 1'b0, ry, rd, lat);
    total++; if (ry !== {NCH{6'h3C}}) begin bad++; $display("FAIL ashr signed y: got %h want %h", ry, {NCH{6'h3C}}); end
    xact(OP_ASHR, 6'h30, 6'h02, 1'b0, 1'b1, ry, rd, lat);
    total++; if (ry !== {NCH{6'h0C}}) begin bad++; $display("FAIL ashr unsigned y: got %h want %h", ry, {NCH{6'h0C}}); end
    xact(OP_ASHR, 6'h30, 6'h09, 1'b1, 1'b1, ry, rd, lat);
    total++; if (ry !== {NCH{6'h3F}}) begin bad++; $display("FAIL ashr saturate y: got %h want %h", ry, {NCH{6'h3F}}); end
    xact(OP_SHL, 6'h03, 6'h02, 1'b0, 1'b0, ry, rd, lat);
    total++; if (ry !== {NCH{6'h0C}}) begin bad++; $display("FAIL shl y: got %h want %h", ry, {NCH{6'h0C}}); end
    xact(OP_SHL, 6'h03, 6'h06, 1'b0, 1'b0, ry, rd, lat);
    total++; if (ry !== {NCH{6'h00}}) begin bad++; $display("FAIL shl overflow y: got %h want 0", ry); end
  endtask
  task automatic test_div;
    logic [NCH*W-1:0] ry;
    logic [NCH-1:0] rd;
    int lat;
    xact(OP_DIV, 6'h2A, 6'h00, 1'b0, 1'b0, ry, rd, lat);
    total++; if (ry !== {NCH{6'h00}}) begin bad++; $display("FAIL div0 y: got %h want 0", ry); end
    total++; if (rd !== {NCH{1'b1}}) begin bad++; $display("FAIL div0 flag: got %b want all ones", rd); end
    xact(OP_MOD, 6'h39, 6'h02, 1'b1, 1'b1, ry, rd, lat);
    total++; if (ry !== {NCH{6'h3F}}) begin bad++; $display("FAIL mod signed y: got %h want %h", ry, {NCH{6'h3F}}); end
    total++; if (rd !== '0) begin bad++; $display("FAIL mod signed div0: got %b want 0", rd); end
    xact(OP_DIV, 6'h39, 6'h02, 1'b1, 1'b1, ry, rd, lat);
    total++; if (ry !== {NCH{6'h3D}}) begin bad++; $display("FAIL div signed y: got %h want %h", ry, {NCH{6'h3D}}); end
    xact(OP_DIV, 6'h39, 6'h02, 1'b1, 1'b0, ry, rd, lat);
    total++; if (ry !== {NCH{6'h1C}}) begin bad++; $display("FAIL div unsigned y: got %h want %h", ry, {NCH{6'h1C}}); end
  endtask
  task automatic test_misc;
    logic [NCH*W-1:0] ry;
    logic [NCH-1:0] rd;
    int lat;
    xact(OP_XORR, 6'h07, 6'h01, 1'b0, 1'b0, ry, rd, lat);
    total++; if (ry !== {NCH{6'h00}}) begin bad++; $display("FAIL xorr even y: got %h want 0", ry); end
    xact(OP_XORR, 6'h07, 6'h00, 1'b0, 1'b0, ry, rd, lat);
    total++; if (ry !== {NCH{6'h01}}) begin bad++; $display("FAIL xorr odd y: got %h want %h", ry, {NCH{6'h01}}); end
    total++; if (rd !== '0) begin bad++; $display("FAIL xorr div0: got %b want 0", rd); end
    xact(OP_MUX, 6'h00, 6'h05, 1'b0, 1'b0, ry, rd, lat);
    total++; if (ry !== {NCH{6'h3A}}) begin bad++; $display("FAIL mux zero y: got %h want %h", ry, {NCH{6'h3A}}); end
    xact(OP_MUX, 6'h01, 6'h05, 1'b0, 1'b0, ry, rd, lat);
    total++; if (ry !== {NCH{6'h05}}) begin bad++; $display("FAIL mux nonzero y: got %h want %h", ry, {NCH{6'h05}}); end
    xact(4'd12, 6'h2A, 6'h00, 1'b0, 1'b0, ry, rd, lat);
    total++; if (ry !== {NCH{6'h00}}) begin bad++; $display("FAIL op12 y: got %h want 0", ry); end
    total++; if (rd !== '0) begin bad++; $display("FAIL op12 div0: got %b want 0", rd); end
  endtask
  task automatic test_back_to_back;
    logic [NCH*W-1:0] got [$];
    int rdy_bad = 0;
    out_ready = 1'b1;
    op = OP_ADD;
    b_flat = {NCH{6'h20}};
    a_signed = '0;
    b_signed = '0;
    for (int i = 0; i < 7; i++) begin
      in_valid = i < 4;
      a_flat = {NCH{6'(i)}};
      if (i < 4 && !in_ready) rdy_bad++;
      tick;
      if (out_valid) got.push_back(y);
    end
    in_valid = 1'b0;
    total++; if (rdy_bad !== 0) begin bad++; $display("FAIL b2b in_ready: got %0d stalls want 0", rdy_bad); end
    total++; if (got.size() !== 4) begin bad++; $display("FAIL b2b count: got %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      logic [NCH*W-1:0] e;
      e = {NCH{6'(i + 32)}};
      total++; if (i >= got.size() || got[i] !== e) begin bad++; $display("FAIL b2b result %0d: got %h want %h", i, i < got.size() ? got[i] : '0, e); end
    end
  endtask
  task automatic test_backpressure;
    int idx = 0;
    logic [NCH*W-1:0] held;
    logic [NCH*W-1:0] got [$];
    out_ready = 1'b0;
    op = OP_ADD;
    b_flat = {NCH{6'h01}};
    a_signed = '0;
    b_signed = '0;
    for (int c = 0; c < 6; c++) begin
      logic take;
      in_valid = idx < 4;
      a_flat = {NCH{6'(idx + 1)}};
      take = in_valid && in_ready;
      tick;
      if (take) idx++;
    end
    total++; if (idx !== 2) begin bad++; $display("FAIL bp accepted: got %0d want 2", idx); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp out_valid: got %b want 1", out_valid); end
    total++; if (y !== {NCH{6'h02}}) begin bad++; $display("FAIL bp head y: got %h want %h", y, {NCH{6'h02}}); end
    held = y;
    tick;
    tick;
    total++; if (y !== held || out_valid !== 1'b1) begin bad++; $display("FAIL bp hold: got %h/%b want %h/1", y, out_valid, held); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) got.push_back(y);
      tick;
    end
    total++; if (got.size() !== 2) begin bad++; $display("FAIL bp drain count: got %0d want 2", got.size()); end
    total++; if (got.size() < 1 || got[0] !== {NCH{6'h02}}) begin bad++; $display("FAIL bp drain first: want %h", {NCH{6'h02}}); end
    total++; if (got.size() < 2 || got[1] !== {NCH{6'h03}}) begin bad++; $display("FAIL bp drain second: want %h", {NCH{6'h03}}); end
  endtask
  task automatic test_reset_mid;
    int seen = 0;
    out_ready = 1'b0;
    op = OP_ADD;
    b_flat = {NCH{6'h01}};
    a_flat = {NCH{6'h10}};
    in_valid = 1'b1;
    tick;
    a_flat = {NCH{6'h11}};
    tick;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid inflight: got %b want 1", out_valid); end
    rst_n = 1'b0;
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid out_valid: got %b want 0", out_valid); end
    total++; if (y !== '0) begin bad++; $display("FAIL rstmid y: got %h want 0", y); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid in_ready: got %b want 1", in_ready); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick;
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rstmid stale: got %0d outputs want 0", seen); end
  endtask
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op = '0;
    a_flat = '0;
    b_flat = '0;
    a_signed = '0;
    b_signed = '0;
    #1;
    test_reset;
    test_arith;
    test_compare;
    test_shift;
    test_div;
    test_misc;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
